// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo core: opcode encodings, reorder-buffer
// sizing, reservation-station index map and the reorder-buffer entry record.
// -----------------------------------------------------------------------------
package tomasulo_pkg;

  // Reorder-buffer sizing (the issue stage assumes 8 entries)
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Opcode encodings carried with every issued instruction
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  // Reservation-station index map
  localparam logic [3:0] RS_LS_FIRST  = 4'd1;
  localparam logic [3:0] RS_LS_LAST   = 4'd6;
  localparam logic [3:0] RS_ADD_FIRST = 4'd7;
  localparam logic [3:0] RS_ADD_LAST  = 4'd9;
  localparam logic [3:0] RS_MUL_FIRST = 4'd10;
  localparam logic [3:0] RS_MUL_LAST  = 4'd11;
  localparam logic [3:0] RS_NONE      = 4'd12;

  // One reorder-buffer slot at the default widths
  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [2:0]        op;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
    logic [31:0]       addr;
  } rob_entry_t;

endpackage

// File: rtl/rob_entry.sv
// -----------------------------------------------------------------------------
// rob_entry
// One reorder-buffer slot: busy/ready flags plus the op, destination, value
// and address fields. The parent decides which slot is allocated, written
// back or cleared; this module only stores.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears everything)
//   alloc_en/op/dest      claim the slot: busy=1, ready=0, latch op and dest
//   wb_en/value/addr      CDB writeback: latch value and address, ready=1
//   clr_en                retire the slot: busy=0, ready=0
//   busy..addr            current slot contents
// -----------------------------------------------------------------------------
module rob_entry #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [2:0]        alloc_op,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [31:0]       wb_addr,
  input  logic              clr_en,
  output logic              busy,
  output logic              ready,
  output logic [2:0]        op,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] value,
  output logic [31:0]       addr
);

  // Slot storage. The three controls are mutually exclusive by construction:
  // allocation needs an idle slot, writeback needs a busy/not-ready slot and
  // retirement needs a busy/ready slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      ready <= 1'b0;
      op    <= 3'd0;
      dest  <= '0;
      value <= '0;
      addr  <= 32'd0;
    end else if (alloc_en) begin
      busy  <= 1'b1;
      ready <= 1'b0;
      op    <= alloc_op;
      dest  <= alloc_dest;
    end else if (clr_en) begin
      busy  <= 1'b0;
      ready <= 1'b0;
    end else if (wb_en) begin
      ready <= 1'b1;
      value <= wb_value;
      addr  <= wb_addr;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer for the Tomasulo core. Entries are allocated in
// order at the tail by the issue stage, completed out of order by CDB
// broadcasts, and retired in order from the head.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   alloc_valid/idx/op/dest        issue-stage allocation request
//   cdb_valid/idx/value/addr       CDB writeback
//   commit_ready                   register file / memory accepts the head
//   commit_valid/idx/op/dest/value/addr   head entry (combinational read)
//   busy                           per-entry busy bits to the issue stage
//   full, empty                    occupancy flags
//   alloc_err                      sticky protocol-violation flag
// Optional feature (macro ROB_LOOKUP_EN): two operand query ports
//   lk0_idx/lk1_idx -> lkN_ready/lkN_value, with same-cycle CDB bypass.
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter  int DEPTH  = tomasulo_pkg::DEPTH,
  parameter  int DATA_W = tomasulo_pkg::DATA_W,
  parameter  int REG_W  = tomasulo_pkg::REG_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [PTR_W-1:0]  alloc_idx,
  input  logic [2:0]        alloc_op,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              cdb_valid,
  input  logic [PTR_W-1:0]  cdb_idx,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic [31:0]       cdb_addr,
  input  logic              commit_ready,
  output logic              commit_valid,
  output logic [PTR_W-1:0]  commit_idx,
  output logic [2:0]        commit_op,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [31:0]       commit_addr,
  output logic [DEPTH-1:0]  busy,
  output logic              full,
  output logic              empty,
  output logic              alloc_err
`ifdef ROB_LOOKUP_EN
  ,
  input  logic [PTR_W-1:0]  lk0_idx,
  input  logic [PTR_W-1:0]  lk1_idx,
  output logic              lk0_ready,
  output logic [DATA_W-1:0] lk0_value,
  output logic              lk1_ready,
  output logic [DATA_W-1:0] lk1_value
`endif
);

  import tomasulo_pkg::*;

  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              alloc_err_r;

  logic [DEPTH-1:0]  busy_s;
  logic [DEPTH-1:0]  ready_s;
  logic [2:0]        op_s    [DEPTH];
  logic [REG_W-1:0]  dest_s  [DEPTH];
  logic [DATA_W-1:0] value_s [DEPTH];
  logic [31:0]       addr_s  [DEPTH];

  logic              alloc_ok_s;
  logic              alloc_bad_s;
  logic              wb_ok_s;
  logic              wb_bad_s;
  logic              commit_fire_s;
  logic [REG_W-1:0]  alloc_dest_s;

  // Qualify allocation, writeback and retirement against current entry state
  always_comb begin
    alloc_ok_s    = 1'b0;
    alloc_bad_s   = 1'b0;
    wb_ok_s       = 1'b0;
    wb_bad_s      = 1'b0;
    alloc_dest_s  = alloc_dest;
    if (alloc_valid) begin
      if ((alloc_idx == tail_r) && !busy_s[tail_r]) begin
        alloc_ok_s = 1'b1;
      end else begin
        alloc_bad_s = 1'b1;
      end
    end else begin
      alloc_ok_s = 1'b0;
    end
    if (cdb_valid) begin
      if (busy_s[cdb_idx] && !ready_s[cdb_idx]) begin
        wb_ok_s = 1'b1;
      end else begin
        wb_bad_s = 1'b1;
      end
    end else begin
      wb_ok_s = 1'b0;
    end
    // Stores have no register destination; keep the field clean
    if (alloc_op == OP_STORE) begin
      alloc_dest_s = '0;
    end else begin
      alloc_dest_s = alloc_dest;
    end
    commit_valid  = busy_s[head_r] && ready_s[head_r];
    commit_fire_s = commit_valid && commit_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      rob_entry #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
      ) u_entry (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (alloc_ok_s && (tail_r == PTR_W'(gi))),
        .alloc_op   (alloc_op),
        .alloc_dest (alloc_dest_s),
        .wb_en      (wb_ok_s && (cdb_idx == PTR_W'(gi))),
        .wb_value   (cdb_value),
        .wb_addr    (cdb_addr),
        .clr_en     (commit_fire_s && (head_r == PTR_W'(gi))),
        .busy       (busy_s[gi]),
        .ready      (ready_s[gi]),
        .op         (op_s[gi]),
        .dest       (dest_s[gi]),
        .value      (value_s[gi]),
        .addr       (addr_s[gi])
      );
    end
  endgenerate

  // Head/tail pointers (wrap silently), occupancy count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      alloc_err_r <= 1'b0;
    end else begin
      if (alloc_ok_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (commit_fire_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({alloc_ok_s, commit_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      alloc_err_r <= alloc_err_r | alloc_bad_s | wb_bad_s;
    end
  end

  assign commit_idx   = head_r;
  assign commit_op    = op_s[head_r];
  assign commit_dest  = dest_s[head_r];
  assign commit_value = value_s[head_r];
  assign commit_addr  = addr_s[head_r];
  assign busy         = busy_s;
  assign full         = (count_r == CNT_W'(DEPTH));
  assign empty        = (count_r == CNT_W'(0));
  assign alloc_err    = alloc_err_r;

`ifdef ROB_LOOKUP_EN
  // Operand lookup with same-cycle CDB bypass
  always_comb begin
    lk0_ready = 1'b0;
    lk0_value = '0;
    lk1_ready = 1'b0;
    lk1_value = '0;
    if (cdb_valid && (cdb_idx == lk0_idx)) begin
      lk0_ready = 1'b1;
      lk0_value = cdb_value;
    end else begin
      lk0_ready = busy_s[lk0_idx] && ready_s[lk0_idx];
      lk0_value = value_s[lk0_idx];
    end
    if (cdb_valid && (cdb_idx == lk1_idx)) begin
      lk1_ready = 1'b1;
      lk1_value = cdb_value;
    end else begin
      lk1_ready = busy_s[lk1_idx] && ready_s[lk1_idx];
      lk1_value = value_s[lk1_idx];
    end
  end
`else
  // Operand lookup ports are not built in this configuration
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against an in-order queue model of the reorder buffer.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [2:0]  alloc_idx;
  logic [2:0]  alloc_op;
  logic [4:0]  alloc_dest;
  logic        cdb_valid;
  logic [2:0]  cdb_idx;
  logic [31:0] cdb_value;
  logic [31:0] cdb_addr;
  logic        commit_ready;
  logic        commit_valid;
  logic [2:0]  commit_idx;
  logic [2:0]  commit_op;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic [31:0] commit_addr;
  logic [7:0]  busy;
  logic        full;
  logic        empty;
  logic        alloc_err;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_idx    (alloc_idx),
    .alloc_op     (alloc_op),
    .alloc_dest   (alloc_dest),
    .cdb_valid    (cdb_valid),
    .cdb_idx      (cdb_idx),
    .cdb_value    (cdb_value),
    .cdb_addr     (cdb_addr),
    .commit_ready (commit_ready),
    .commit_valid (commit_valid),
    .commit_idx   (commit_idx),
    .commit_op    (commit_op),
    .commit_dest  (commit_dest),
    .commit_value (commit_value),
    .commit_addr  (commit_addr),
    .busy         (busy),
    .full         (full),
    .empty        (empty),
    .alloc_err    (alloc_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: in-order queue of live entries -------
  typedef struct {
    int          idx;
    logic [2:0]  op;
    logic [4:0]  dest;
    bit          rdy;
    logic [31:0] value;
    logic [31:0] addr;
  } ment_t;

  ment_t mq[$];
  int    m_head;
  bit    m_err;
  bit    chk_en = 1'b0;

  function automatic int m_tail();
    return (m_head + mq.size()) % 8;
  endfunction

  function automatic int m_find(input int idx);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].idx == idx) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head = 0;
    m_err  = 1'b0;
  endtask

  // Apply one clock edge's worth of rules to the model, using the inputs
  // presented in the cycle that just ended.
  task automatic model_step();
    bit    fire;
    bit    do_alloc;
    int    wi;
    ment_t ne;
    fire     = (mq.size() > 0) && mq[0].rdy && commit_ready;
    do_alloc = 1'b0;
    if (alloc_valid) begin
      if ((int'(alloc_idx) == m_tail()) && (m_find(int'(alloc_idx)) < 0)) do_alloc = 1'b1;
      else m_err = 1'b1;
    end
    if (cdb_valid) begin
      wi = m_find(int'(cdb_idx));
      if (wi >= 0 && !mq[wi].rdy) begin
        mq[wi].rdy   = 1'b1;
        mq[wi].value = cdb_value;
        mq[wi].addr  = cdb_addr;
      end else begin
        m_err = 1'b1;
      end
    end
    if (fire) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % 8;
    end
    if (do_alloc) begin
      ne.idx   = int'(alloc_idx);
      ne.op    = alloc_op;
      ne.dest  = (alloc_op == 3'd5) ? 5'd0 : alloc_dest;
      ne.rdy   = 1'b0;
      ne.value = 32'd0;
      ne.addr  = 32'd0;
      mq.push_back(ne);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [7:0] eb;
    bit         hv;
    if (chk_en) begin
      eb = 8'd0;
      for (int i = 0; i < mq.size(); i++) eb[mq[i].idx] = 1'b1;
      hv = (mq.size() > 0) && mq[0].rdy;
      chk("busy", 64'(busy), 64'(eb));
      chk("full", 64'(full), 64'(mq.size() == 8));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("alloc_err", 64'(alloc_err), 64'(m_err));
      chk("commit_valid", 64'(commit_valid), 64'(hv));
      chk("commit_idx", 64'(commit_idx), 64'(m_head));
      if (hv) begin
        chk("commit_op", 64'(commit_op), 64'(mq[0].op));
        chk("commit_dest", 64'(commit_dest), 64'(mq[0].dest));
        chk("commit_value", 64'(commit_value), 64'(mq[0].value));
        chk("commit_addr", 64'(commit_addr), 64'(mq[0].addr));
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step(input logic av, input logic [2:0] aidx, input logic [2:0] aop,
                      input logic [4:0] adest, input logic cv, input logic [2:0] cidx,
                      input logic [31:0] cval, input logic [31:0] caddr, input logic cr);
    alloc_valid  = av;
    alloc_idx    = aidx;
    alloc_op     = aop;
    alloc_dest   = adest;
    cdb_valid    = cv;
    cdb_idx      = cidx;
    cdb_value    = cval;
    cdb_addr     = caddr;
    commit_ready = cr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random traffic; with_err allows mismatched/duplicate indices
  task automatic rand_run(input int cycles, input bit with_err);
    int          cand[$];
    logic        av, cv, cr;
    logic [2:0]  aidx, cidx;
    for (int c = 0; c < cycles; c++) begin
      cand.delete();
      for (int i = 0; i < mq.size(); i++) if (!mq[i].rdy) cand.push_back(mq[i].idx);
      av   = ($urandom_range(3, 0) != 0) && (with_err || mq.size() < 8);
      aidx = 3'(m_tail());
      if (with_err && $urandom_range(4, 0) == 0) aidx = 3'($urandom_range(7, 0));
      cv   = 1'b0;
      cidx = 3'd0;
      if (cand.size() > 0 && $urandom_range(2, 0) != 0) begin
        cv   = 1'b1;
        cidx = 3'(cand[$urandom_range(cand.size() - 1, 0)]);
      end
      if (with_err && $urandom_range(5, 0) == 0) begin
        cv   = 1'b1;
        cidx = 3'($urandom_range(7, 0));
      end
      cr = ($urandom_range(3, 0) != 0);
      step(av, aidx, 3'($urandom_range(5, 0)), 5'($urandom_range(31, 0)),
           cv, cidx, $urandom(), $urandom(), cr);
    end
  endtask

  // ---------------- scenario sequence --------------------------------------
  initial begin
    rst_n = 1'b0;
    step_init();
    model_reset();
    #12;
    // Reset state
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'h00);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_alloc_err", 64'(alloc_err), 64'd0);
    chk("rst_commit_value", 64'(commit_value), 64'd0);
    chk("rst_commit_dest", 64'(commit_dest), 64'd0);
    chk("rst_commit_addr", 64'(commit_addr), 64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // ADD to idx 0 dest 3, then CDB(0, 5)
    step(1'b1, 3'd0, 3'd0, 5'd3, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("t1_busy", 64'(busy), 64'h01);
    chk("t1_empty", 64'(empty), 64'd0);
    chk("t1_commit_valid_early", 64'(commit_valid), 64'd0);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b1, 3'd0, 32'h5, 32'h0, 1'b0);
    chk("t1_commit_valid", 64'(commit_valid), 64'd1);
    chk("t1_commit_dest", 64'(commit_dest), 64'd3);
    chk("t1_commit_value", 64'(commit_value), 64'h5);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("t1_empty_after", 64'(empty), 64'd1);

    // Fill all 8 entries starting at tail=1, then a ninth allocation
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 3'((1 + k) % 8), 3'(k % 6), 5'(k + 1), 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    end
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_busy", 64'(busy), 64'hFF);
    chk("t2_err_before", 64'(alloc_err), 64'd0);
    step(1'b1, 3'd1, 3'd0, 5'd9, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("t2_alloc_err", 64'(alloc_err), 64'd1);
    chk("t2_busy_kept", 64'(busy), 64'hFF);
    do_reset();

    // Out-of-order completion, in-order retirement
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'(k), 3'd1, 5'(10 + k), 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    end
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b1, 3'd2, 32'h22, 32'h0, 1'b1);
    chk("t3_wait_cdb2", 64'(commit_valid), 64'd0);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b1, 3'd1, 32'h11, 32'h0, 1'b1);
    chk("t3_wait_cdb1", 64'(commit_valid), 64'd0);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b1, 3'd0, 32'h10, 32'h0, 1'b1);
    chk("t3_head0_idx", 64'(commit_idx), 64'd0);
    chk("t3_head0_val", 64'(commit_value), 64'h10);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("t3_head1_idx", 64'(commit_idx), 64'd1);
    chk("t3_head1_val", 64'(commit_value), 64'h11);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("t3_head2_idx", 64'(commit_idx), 64'd2);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("t3_empty", 64'(empty), 64'd1);

    // Back-pressure: head ready but commit_ready low holds the outputs
    step(1'b1, 3'd3, 3'd5, 5'd7, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 3'd4, 3'd2, 5'd8, 1'b1, 3'd3, 32'hABCD, 32'h1000, 1'b0);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b1, 3'd4, 32'h77, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      chk("t4_hold_idx", 64'(commit_idx), 64'd3);
      chk("t4_hold_value", 64'(commit_value), 64'hABCD);
      chk("t4_hold_addr", 64'(commit_addr), 64'h1000);
      chk("t4_hold_dest", 64'(commit_dest), 64'd0);
    end
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("t4_next_idx", 64'(commit_idx), 64'd4);
    chk("t4_next_value", 64'(commit_value), 64'h77);
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("t4_empty", 64'(empty), 64'd1);

    // Randomized traffic: clean (pointers wrap) then with protocol errors
    rand_run(60, 1'b0);
    chk("t5_no_err", 64'(alloc_err), 64'd0);
    rand_run(300, 1'b1);

    // Asynchronous reset mid-sequence with 5 entries busy
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'(k), 3'd0, 5'(k), 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    end
    chk("t6_busy_before", 64'(busy), 64'h1F);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_busy_async", 64'(busy), 64'h00);
    chk("t6_empty_async", 64'(empty), 64'd1);
    chk("t6_commit_valid_async", 64'(commit_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic step_init();
    alloc_valid  = 1'b0;
    alloc_idx    = 3'd0;
    alloc_op     = 3'd0;
    alloc_dest   = 5'd0;
    cdb_valid    = 1'b0;
    cdb_idx      = 3'd0;
    cdb_value    = 32'd0;
    cdb_addr     = 32'd0;
    commit_ready = 1'b0;
  endtask

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

8-entry circular reorder buffer for the Tomasulo core. It sits directly downstream of the issue stage. The issue stage allocates entries at its `reorder_buffer_idx`, and the per-entry busy bits feed back into that stage's structural-hazard check. Entries are completed out of order by CDB broadcasts and retired strictly in order to the register file or to memory.

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must be a power of two; the issue stage assumes 8.
- `DATA_W`, 32: result and store-data width.
- `REG_W`, 5: architectural destination register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alloc_valid` in 1: an instruction issues this cycle (`start && !struct_haz`).
- `alloc_idx` in 3: target entry, driven from the issue stage's `reorder_buffer_idx`.
- `alloc_op` in 3: opcode. ADD=0, SUB=1, MUL=2, DIV=3, LOAD=4, STORE=5.
- `alloc_dest` in REG_W: destination register. Ignored for STORE.
- `cdb_valid` in 1: CDB broadcast this cycle.
- `cdb_idx` in 3: ROB tag of the broadcast.
- `cdb_value` in DATA_W: result, or store data for a STORE.
- `cdb_addr` in 32: effective address. Used only by STORE entries.
- `commit_ready` in 1: the register file or memory accepts the commit.
- `commit_valid` out 1: the head entry is ready to retire.
- `commit_idx` out 3: head entry index.
- `commit_op` out 3: head entry opcode.
- `commit_dest` out REG_W: head entry destination register.
- `commit_value` out DATA_W: head entry value.
- `commit_addr` out 32: head entry address.
- `busy` out DEPTH: bit i drives `busy_rb<i>` of the issue stage.
- `full` out 1: all DEPTH entries are busy.
- `empty` out 1: no entry is busy.
- `alloc_err` out 1: sticky protocol-violation flag.

## Operation
Each entry holds these fields: `busy`, `ready`, `op`, `dest`, `value`, `addr`. The block keeps a `head` pointer, a `tail` pointer and a 4-bit `count` (0..8).

Allocation:
- Occurs when `alloc_valid` is high, `alloc_idx` equals `tail`, and the entry is not busy.
- Sets `busy`=1, `ready`=0, and latches `op` and `dest`.
- Increments `tail` modulo 8.
- If `alloc_valid` is high with a mismatched index or a busy entry, the allocation is dropped and `alloc_err` is set.

Writeback:
- Occurs when `cdb_valid` is high and entry `cdb_idx` is busy and not ready.
- Latches `value`, latches `addr`, and sets `ready`=1.
- A CDB broadcast to an idle entry or to an already-ready entry is ignored and sets `alloc_err`.

Commit:
- `commit_valid` = `busy[head] && ready[head]`. All `commit_*` fields are combinational reads of the head entry.
- On `commit_valid && commit_ready`:
  - `busy[head]` clears.
  - `head` increments modulo 8.
- `commit_valid` must stay stable until it is accepted.

Occupancy:
- `count` increments on allocation, decrements on commit, and is unchanged when both happen in the same cycle.
- `full` = (`count` == 8); `empty` = (`count` == 0).

Simultaneous events:
- Allocation, writeback and commit may all occur in the same cycle on distinct entries.
- Writeback and commit on the same entry cannot coincide, because commit requires `ready` to be set already.
- Pointer wrap-around from 7 to 0 is silent.

Reset:
- All `busy` and `ready` bits clear, `head`=`tail`=0, `count`=0, `alloc_err`=0.
- Resulting outputs: `commit_valid`=0, `busy`=0, `full`=0, `empty`=1.
- All `commit_*` fields read as 0.
- Reset asserted mid-operation discards every entry immediately, without waiting for a clock edge.

## Timing
- Allocation at edge t: `busy` is visible from t, so the issue stage sees the new bit in the following cycle.
- CDB broadcast in cycle c: the earliest cycle `commit_valid` can rise is c+1. There is no same-cycle CDB-to-commit bypass.
- Commit accepted at edge t: the entry's `busy` bit drops after t. It can be re-allocated in the cycle after t, not in the same cycle.
- Full throughput: 1 allocation, 1 writeback and 1 commit per cycle.

## Configuration
- Macro: `ROB_LOOKUP_EN`.
- Defined: the block adds two operand query ports.
  - Inputs: `lk0_idx`, `lk1_idx` (3 bits each).
  - Outputs: `lk0_ready`, `lk0_value`, `lk1_ready`, `lk1_value`.
  - The outputs are combinational.
  - If `cdb_valid` is high with a matching `cdb_idx` in the same cycle, the result is ready=1 and the CDB value (same-cycle bypass).
- Undefined: these ports and their logic are absent.

## Structure
- Shared package `tomasulo_pkg` contains:
  - the opcode constants (ADD..STORE);
  - DEPTH, DATA_W and REG_W;
  - reservation-station index constants (LS 1-6, ADD 7-9, MUL 10-11, none 12);
  - the `rob_entry_t` struct.
- One sub-module, `rob_entry`: a single slot's registers plus its allocate, writeback and clear logic. The top level instantiates DEPTH copies.

## Test plan
- Reset, then allocate ADD to idx 0 with dest 3 → `busy`=8'h01 and `empty`=0. Then CDB (0, 32'h5) → next cycle `commit_valid`=1, `commit_dest`=3, `commit_value`=5.
- Allocate 8 entries back to back → `full`=1 and `busy`=8'hFF. A ninth `alloc_valid` → dropped and `alloc_err`=1.
- Allocate idx 0-2, then CDB 2, then CDB 1 → `commit_valid` stays 0 until CDB 0 arrives. Then commits occur in order 0, 1, 2.
- Hold `commit_ready`=0 with the head ready → `commit_*` stays stable. Raise it → exactly one retire per cycle.
- Run 20 allocate/commit cycles → `head` and `tail` wrap 7→0 and `count` never exceeds 8.
- Assert `rst_n`=0 mid-sequence with 5 entries busy → `busy`=0 and `empty`=1 immediately, without waiting for a clock edge.
